// File: rtl/os_xor_pkg.sv
// Shared types and defaults for the XOR frame accumulator that follows the OS_XOR2 product stage.
package os_xor_pkg;

    localparam int W_DEF     = 7;
    localparam int LEN_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } acc_state_e;

    typedef struct packed {
        logic [W_DEF-1:0]     data;
        logic [LEN_W_DEF-1:0] frame_id;
    } syndrome_t;

endpackage

// File: rtl/os_xor_out_slot.sv
// Single-entry valid/ready output register; a load wins over an emit in the same cycle so the slot refills without a bubble.
module os_xor_out_slot #(
    parameter int W     = 7,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             emit,
    input  logic [W-1:0]     load_data,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [LEN_W-1:0] frame_id
);

    // Slot contents and the running frame sequence number.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= {W{1'b0}};
            frame_id  <= {LEN_W{1'b0}};
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            frame_id  <= frame_id + LEN_W'(1);
        end else if (emit) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

endmodule

// File: rtl/os_xor_frame_accum.sv
// Folds product-stage words into a per-frame XOR syndrome and hands each syndrome to a one-entry output slot.
module os_xor_frame_accum
    import os_xor_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic [LEN_W-1:0] frame_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic             out_parity,
    output logic [LEN_W-1:0] out_frame_id
);

    function automatic logic calc_parity(input logic [W-1:0] d);
        return ^d;
    endfunction

    acc_state_e       state_r;
    acc_state_e       state_nxt_s;
    logic [W-1:0]     acc_r;
    logic [LEN_W-1:0] cnt_r;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] len_m1_s;
    logic [W-1:0]     acc_nxt_s;
    logic [W-1:0]     load_data_s;
    logic             accept_s;
    logic             emit_s;
    logic             last_s;
    logic             slot_free_s;
    logic             load_s;

    // in_ready depends on state and control inputs only, never on out_ready.
    assign in_ready    = rst_n && !clear && (state_r != HOLD);
    assign accept_s    = in_valid && in_ready;
    assign emit_s      = out_valid && out_ready;
    assign slot_free_s = !out_valid || emit_s;
    // len_r == 0 wraps to all-ones, so a zero length runs for 2^LEN_W beats.
    assign len_m1_s    = len_r - LEN_W'(1);
    assign out_parity  = calc_parity(out_data);

    // Last-beat detection and the accumulator value after this beat.
    always_comb begin
        last_s    = 1'b0;
        acc_nxt_s = acc_r ^ in_data;
        case (state_r)
            IDLE: begin
                last_s    = (frame_len == LEN_W'(1));
                acc_nxt_s = in_data;
            end
            ACCUM: begin
                last_s    = (cnt_r == len_m1_s);
                acc_nxt_s = acc_r ^ in_data;
            end
            HOLD: begin
                last_s    = 1'b0;
                acc_nxt_s = acc_r;
            end
            default: begin
                last_s    = 1'b0;
                acc_nxt_s = acc_r;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; clear always returns to IDLE, dropping any held result.
    always_comb begin
        state_nxt_s = state_r;
        if (clear) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s && last_s) begin
                        state_nxt_s = slot_free_s ? IDLE : HOLD;
                    end else if (accept_s) begin
                        state_nxt_s = ACCUM;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                ACCUM: begin
                    if (accept_s && last_s) begin
                        state_nxt_s = slot_free_s ? IDLE : HOLD;
                    end else begin
                        state_nxt_s = ACCUM;
                    end
                end
                HOLD: begin
                    if (emit_s) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = HOLD;
                    end
                end
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // FSM outputs: when and what to load into the output slot.
    always_comb begin
        load_s      = 1'b0;
        load_data_s = acc_nxt_s;
        case (state_r)
            IDLE, ACCUM: begin
                load_s      = accept_s && last_s && slot_free_s;
                load_data_s = acc_nxt_s;
            end
            HOLD: begin
                load_s      = emit_s && !clear;
                load_data_s = acc_r;
            end
            default: begin
                load_s      = 1'b0;
                load_data_s = acc_nxt_s;
            end
        endcase
    end

    // Accumulator, beat counter and latched frame length.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r <= {W{1'b0}};
            cnt_r <= {LEN_W{1'b0}};
            len_r <= {LEN_W{1'b0}};
        end else if (clear) begin
            acc_r <= {W{1'b0}};
            cnt_r <= {LEN_W{1'b0}};
        end else if (accept_s) begin
            acc_r <= acc_nxt_s;
            if (state_r == IDLE) begin
                len_r <= frame_len;
                cnt_r <= LEN_W'(1);
            end else begin
                cnt_r <= cnt_r + LEN_W'(1);
            end
        end else begin
            acc_r <= acc_r;
        end
    end

    os_xor_out_slot #(
        .W     (W),
        .LEN_W (LEN_W)
    ) u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_s),
        .emit      (emit_s),
        .load_data (load_data_s),
        .out_valid (out_valid),
        .out_data  (out_data),
        .frame_id  (out_frame_id)
    );

endmodule

// File: tb/tb_os_xor_frame_accum.sv
// Directed, table-driven bench for os_xor_frame_accum with hand-computed expectations.
module tb_os_xor_frame_accum;
    import os_xor_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] in_data;
    logic [7:0] frame_len;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] out_data;
    logic       out_parity;
    logic [7:0] out_frame_id;

    int checks   = 0;
    int failures = 0;

    os_xor_frame_accum dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .frame_len    (frame_len),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_parity   (out_parity),
        .out_frame_id (out_frame_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic      rst;
        logic      clr;
        logic      vld;
        logic [6:0] dat;
        logic [7:0] len;
        logic      ordy;
        logic      exp_rdy;
        logic      exp_vld;
        syndrome_t exp_syn;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic c, input logic v, input logic [6:0] d,
                                input logic [7:0] l, input logic o, input logic er, input logic ev,
                                input logic [6:0] ed, input logic [7:0] ef);
        vec_t t;
        t.rst = r; t.clr = c; t.vld = v; t.dat = d; t.len = l; t.ordy = o;
        t.exp_rdy = er; t.exp_vld = ev;
        t.exp_syn.data = ed; t.exp_syn.frame_id = ef;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Drive one cycle, check in_ready before the edge and the slot after it.
    task automatic step(input vec_t t, input string nm);
        rst_n = t.rst; clear = t.clr; in_valid = t.vld; in_data = t.dat;
        frame_len = t.len; out_ready = t.ordy;
        #1;
        chk({nm, " in_ready"}, {31'd0, in_ready}, {31'd0, t.exp_rdy});
        @(posedge clk);
        #1;
        chk({nm, " out_valid"}, {31'd0, out_valid}, {31'd0, t.exp_vld});
        chk({nm, " out_data"}, {25'd0, out_data}, {25'd0, t.exp_syn.data});
        chk({nm, " out_parity"}, {31'd0, out_parity}, {31'd0, ^t.exp_syn.data});
        chk({nm, " frame_id"}, {24'd0, out_frame_id}, {24'd0, t.exp_syn.frame_id});
    endtask

    vec_t vecs[26];

    initial begin
        //              rst  clr  vld  data   len    ordy  rdy  ov   od     fid
        vecs[0]  = mk(1'b0,1'b0,1'b0,7'h00,8'd0, 1'b0, 1'b0,1'b0,7'h00,8'd0);
        // length 4: 01^02^04^08
        vecs[1]  = mk(1'b1,1'b0,1'b1,7'h01,8'd4, 1'b1, 1'b1,1'b0,7'h00,8'd0);
        vecs[2]  = mk(1'b1,1'b0,1'b1,7'h02,8'd4, 1'b1, 1'b1,1'b0,7'h00,8'd0);
        vecs[3]  = mk(1'b1,1'b0,1'b1,7'h04,8'd4, 1'b1, 1'b1,1'b0,7'h00,8'd0);
        vecs[4]  = mk(1'b1,1'b0,1'b1,7'h08,8'd4, 1'b1, 1'b1,1'b1,7'h0F,8'd1);
        // length 1, back to back with emit + reload
        vecs[5]  = mk(1'b1,1'b0,1'b1,7'h55,8'd1, 1'b1, 1'b1,1'b1,7'h55,8'd2);
        vecs[6]  = mk(1'b1,1'b0,1'b1,7'h2A,8'd1, 1'b1, 1'b1,1'b1,7'h2A,8'd3);
        vecs[7]  = mk(1'b1,1'b0,1'b1,7'h7F,8'd1, 1'b1, 1'b1,1'b1,7'h7F,8'd4);
        vecs[8]  = mk(1'b1,1'b0,1'b0,7'h00,8'd1, 1'b1, 1'b1,1'b0,7'h7F,8'd4);
        // length 2 with a stalled consumer: second frame lands in HOLD
        vecs[9]  = mk(1'b1,1'b0,1'b1,7'h11,8'd2, 1'b0, 1'b1,1'b0,7'h7F,8'd4);
        vecs[10] = mk(1'b1,1'b0,1'b1,7'h22,8'd2, 1'b0, 1'b1,1'b1,7'h33,8'd5);
        vecs[11] = mk(1'b1,1'b0,1'b1,7'h33,8'd2, 1'b0, 1'b1,1'b1,7'h33,8'd5);
        vecs[12] = mk(1'b1,1'b0,1'b1,7'h44,8'd2, 1'b0, 1'b1,1'b1,7'h33,8'd5);
        vecs[13] = mk(1'b1,1'b0,1'b1,7'h55,8'd2, 1'b0, 1'b0,1'b1,7'h33,8'd5);
        vecs[14] = mk(1'b1,1'b0,1'b0,7'h00,8'd2, 1'b1, 1'b0,1'b1,7'h77,8'd6);
        vecs[15] = mk(1'b1,1'b0,1'b0,7'h00,8'd2, 1'b1, 1'b1,1'b0,7'h77,8'd6);
        // length 3 aborted by clear; the clear-cycle beat is refused
        vecs[16] = mk(1'b1,1'b0,1'b1,7'h10,8'd3, 1'b1, 1'b1,1'b0,7'h77,8'd6);
        vecs[17] = mk(1'b1,1'b0,1'b1,7'h20,8'd3, 1'b1, 1'b1,1'b0,7'h77,8'd6);
        vecs[18] = mk(1'b1,1'b1,1'b1,7'h40,8'd3, 1'b1, 1'b0,1'b0,7'h77,8'd6);
        vecs[19] = mk(1'b1,1'b0,1'b1,7'h01,8'd3, 1'b1, 1'b1,1'b0,7'h77,8'd6);
        vecs[20] = mk(1'b1,1'b0,1'b1,7'h02,8'd3, 1'b1, 1'b1,1'b0,7'h77,8'd6);
        vecs[21] = mk(1'b1,1'b0,1'b1,7'h04,8'd3, 1'b1, 1'b1,1'b1,7'h07,8'd7);
        // reset mid-frame with the slot full
        vecs[22] = mk(1'b1,1'b0,1'b1,7'h09,8'd5, 1'b0, 1'b1,1'b1,7'h07,8'd7);
        vecs[23] = mk(1'b0,1'b0,1'b1,7'h0A,8'd5, 1'b0, 1'b0,1'b0,7'h00,8'd0);
        vecs[24] = mk(1'b1,1'b0,1'b1,7'h03,8'd2, 1'b1, 1'b1,1'b0,7'h00,8'd0);
        vecs[25] = mk(1'b1,1'b0,1'b1,7'h05,8'd2, 1'b1, 1'b1,1'b1,7'h06,8'd1);

        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 7'h00;
        frame_len = 8'd0; out_ready = 1'b0;

        for (int i = 0; i < 26; i++) begin
            step(vecs[i], $sformatf("v%0d", i));
        end

        // frame_len 0 means 256 beats; a mid-frame length change is ignored
        for (int i = 0; i < 256; i++) begin
            step(mk(1'b1, 1'b0, 1'b1, 7'h01, (i == 0) ? 8'd0 : 8'd3, 1'b1, 1'b1,
                    (i == 255), (i == 255) ? 7'h00 : 7'h06, (i == 255) ? 8'd2 : 8'd1),
                 $sformatf("len0 beat%0d", i));
        end

        // a result parked in HOLD is discarded by clear; the slot keeps its old value
        step(mk(1'b1,1'b0,1'b1,7'h11,8'd1, 1'b0, 1'b1,1'b1,7'h00,8'd2), "hold_in");
        step(mk(1'b1,1'b1,1'b0,7'h00,8'd1, 1'b0, 1'b0,1'b1,7'h00,8'd2), "hold_clear");
        step(mk(1'b1,1'b0,1'b0,7'h00,8'd1, 1'b1, 1'b1,1'b0,7'h00,8'd2), "hold_drain");
        step(mk(1'b1,1'b0,1'b0,7'h00,8'd1, 1'b1, 1'b1,1'b0,7'h00,8'd2), "hold_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/os_xor_frame_accum.md
# os_xor_frame_accum

Downstream consumer of the OS_XOR2 product stage. Takes the 7-bit XOR-reduced partial-product word `y` each cycle under valid/ready and folds consecutive words into a per-frame syndrome (running XOR) over a programmable frame length. Emits one syndrome per frame through a single-entry output slot with backpressure. Sits between the combinational product array and the result collector.

## Interface
- `W`, 7, data width; matches product-stage `y` width.
- `LEN_W`, 8, frame-length/counter width.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `clear`  in  1  synchronous abort of the in-progress frame.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  block accepts a beat.
- `in_data`  in  W  product-stage word `y`.
- `frame_len`  in  LEN_W  beats per frame; sampled on the first beat of each frame; 0 means 2^LEN_W.
- `out_valid`  out  1  syndrome available.
- `out_ready`  in  1  consumer takes the syndrome.
- `out_data`  out  W  frame syndrome, XOR of all beats in the frame.
- `out_parity`  out  1  XOR of the bits of `out_data`.
- `out_frame_id`  out  LEN_W  frame sequence number, wraps modulo 2^LEN_W.

## Operation
- Accept: `in_valid && in_ready`. Emit: `out_valid && out_ready`.
- FSM states: IDLE, ACCUM, HOLD.
- IDLE: on accept, latch `len`=`frame_len`, set `acc`=`in_data`, `cnt`=1. If len==1, treat as last beat. Otherwise go to ACCUM.
- ACCUM: on accept, `acc`^=`in_data`, `cnt`+=1. The last beat is the one where `cnt`==len-1 (mod 2^LEN_W) before the increment.
- On the last beat:
  - If the slot is empty, or the slot is emitting this cycle, load `out_data`=final acc, set `out_valid`=1, increment `frame_id`, go to IDLE.
  - Otherwise keep the final value in `acc` and go to HOLD.
- HOLD: `in_ready`=0. On emit of the old slot, load `acc` into the slot in the same edge, keep `out_valid`=1, increment `frame_id`, go to IDLE.
- `in_ready` = `rst_n && !clear && state!=HOLD`. It is a function of state only and never depends on `out_ready`.
- `clear`:
  - Forces IDLE and zeroes `acc` and `cnt`.
  - Discards a HOLD result.
  - Blocks acceptance in the same cycle.
  - Leaves the output slot and `frame_id` untouched.
- `frame_len` changes mid-frame are ignored.
- `out_parity` is combinational from `out_data`.

## Timing
- Reset values: state IDLE, `acc`=0, `cnt`=0, `len`=0, `out_valid`=0, `out_data`=0, `out_frame_id`=0. `in_ready` is 0 while `rst_n`=0.
- Latency: a last beat accepted at edge t gives `out_valid`=1 from edge t onward, i.e. visible in cycle t+1.
- Throughput: with `out_ready` held 1, one beat per cycle with no bubbles, including back-to-back frames of length 1.
- Emit and a new last beat in the same cycle: the slot is reloaded, with no bubble and no loss.
- Slot stays full (`out_ready`=0): the block reaches HOLD after the next frame completes and stalls input until the slot drains.
- Reset asserted mid-frame or in HOLD: all state is lost; the first post-reset beat starts a new frame.
- `cnt` and `frame_id` wrap naturally modulo 2^LEN_W.

## Structure
- Package `os_xor_pkg`:
  - `W` and `LEN_W` defaults.
  - FSM enum `acc_state_e` {IDLE, ACCUM, HOLD}.
  - Syndrome struct {`data`, `frame_id`}.
- Sub-module `os_xor_out_slot`: single-entry valid/ready register. Inputs are load, emit and load data; it produces `out_valid`, `out_data` and `frame_id`.
- Top module holds the FSM, `acc`, `cnt` and `len`.

## Test plan
- Length 4, `out_ready`=1, beats 0x01,0x02,0x04,0x08 → one syndrome 0x0F, `out_parity`=0, `frame_id`=1, `out_valid` asserted the cycle after the 4th accept.
- `frame_len`=1, continuous beats 0x55,0x2A,0x7F, `out_ready`=1 → three syndromes 0x55,0x2A,0x7F on consecutive cycles; `in_ready` never drops.
- `frame_len`=2, `out_ready`=0: beats 0x11,0x22 then 0x33,0x44 → slot=0x33, block in HOLD, `in_ready`=0. Raise `out_ready` → emits 0x33, then 0x77, `frame_id` 1 then 2.
- `frame_len`=0, 256 beats all 0x01 → syndrome 0x00, emitted exactly after beat 256.
- `frame_len`=3, two beats 0x10,0x20, then `clear` pulse, then beats 0x01,0x02,0x04 → single syndrome 0x07. `clear`-cycle beat not accepted.
- `rst_n` low for one cycle mid-frame with `out_valid`=1 → all outputs 0 next cycle; following 2-beat frame 0x03,0x05 → 0x06 with `frame_id`=1.
